// File: rtl/spike_rate_avg.sv
// Moving-average firing rate over the last 2^LOG2_DEPTH spike-count windows,
// published through a valid/ready handshake with a sticky overrun flag.
module spike_rate_avg #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned LOG2_DEPTH = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CNT_W-1:0]            cnt_in,
  input  logic                        cnt_stb,
  input  logic                        clear,
  output logic [CNT_W-1:0]            rate_out,
  output logic                        rate_valid,
  input  logic                        rate_ready,
  output logic [CNT_W+LOG2_DEPTH-1:0] sum_out,
  output logic                        filled,
  output logic                        overrun
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = CNT_W + LOG2_DEPTH;

  typedef enum logic {FILL, RUN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        hist [DEPTH];
  logic [LOG2_DEPTH-1:0]   wr_ptr;
  logic [LOG2_DEPTH-1:0]   fill_cnt;
  logic [SUM_W-1:0]        sum_next;
  logic                    load;

  // The outgoing entry is part of the sum, so this subtraction cannot underflow.
  always_comb begin
    sum_next = sum_out + SUM_W'(cnt_in) - SUM_W'(hist[wr_ptr]);
    load     = cnt_stb && ((state == RUN) ||
                           (fill_cnt == LOG2_DEPTH'(DEPTH - 1)));
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < int'(DEPTH); i++) hist[i] <= '0;
      state      <= FILL;
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      sum_out    <= '0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      filled     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (cnt_stb) begin
        hist[wr_ptr] <= cnt_in;
        wr_ptr       <= wr_ptr + 1'b1;
        sum_out      <= sum_next;
        if (state == FILL) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == LOG2_DEPTH'(DEPTH - 1)) begin
            state  <= RUN;
            filled <= 1'b1;
          end
        end
      end

      // A newer result replaces an unconsumed one and flags the loss.
      if (load) begin
        rate_out   <= CNT_W'(sum_next >> LOG2_DEPTH);
        rate_valid <= 1'b1;
        if (rate_valid && !rate_ready) overrun <= 1'b1;
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_avg.sv
// Directed and randomized checks of spike_rate_avg against a queue-based
// moving-average model.
module tb_spike_rate_avg;

  logic        clk = 1'b0;
  logic        reset, clear, cnt_stb, rate_ready;
  logic [31:0] cnt_in;
  logic [31:0] rate_out;
  logic        rate_valid, filled, overrun;
  logic [34:0] sum_out;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: the accepted samples themselves, not a register image.
  logic [31:0] q[$];
  int          m_n;
  logic [34:0] m_sum;
  logic [31:0] m_rate;
  bit          m_valid, m_ovr;

  always #5 clk = ~clk;

  spike_rate_avg #(.CNT_W(32), .LOG2_DEPTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .cnt_stb    (cnt_stb),
    .clear      (clear),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .sum_out    (sum_out),
    .filled     (filled),
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [34:0] window_sum();
    logic [34:0] s = '0;
    foreach (q[i]) s += 35'(q[i]);
    return s;
  endfunction

  // One clock: drive inputs, advance the model at the edge, check all outputs.
  task automatic cycle(input bit r, input bit c, input bit s,
                       input logic [31:0] v, input bit rdy);
    reset = r; clear = c; cnt_stb = s; cnt_in = v; rate_ready = rdy;
    @(posedge clk);
    if (r || c) begin
      q.delete();
      m_n = 0; m_sum = '0; m_rate = '0; m_valid = 0; m_ovr = 0;
    end else begin
      bit load;
      load = 0;
      if (s) begin
        q.push_back(v);
        if (q.size() > 8) void'(q.pop_front());
        if (m_n < 8) m_n++;
        m_sum = window_sum();
        load  = (m_n == 8);
      end
      if (load) begin
        if (m_valid && !rdy) m_ovr = 1;
        m_valid = 1;
        m_rate  = 32'(m_sum >> 3);
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
    #1;
    chk("sum_out",    64'(sum_out),    64'(m_sum));
    chk("rate_out",   64'(rate_out),   64'(m_rate));
    chk("rate_valid", 64'(rate_valid), 64'(m_valid));
    chk("filled",     64'(filled),     64'(m_n >= 8));
    chk("overrun",    64'(overrun),    64'(m_ovr));
    reset = 0; clear = 0; cnt_stb = 0;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cycle(0, 0, 0, 32'd0, rdy);
  endtask

  initial begin
    logic [34:0] exp_sum [4];
    logic [31:0] exp_rate[4];
    exp_sum  = '{35'd88, 35'd96, 35'd104, 35'd112};
    exp_rate = '{32'd11, 32'd12, 32'd13, 32'd14};
    reset = 1; clear = 0; cnt_stb = 0; cnt_in = '0; rate_ready = 1;

    // 1: fill with 10s, result only on the eighth strobe
    cycle(1, 0, 0, 32'd0, 1);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_valid", 64'(rate_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 32'd10, 1);
      if (i < 7) begin
        chk("s1_novalid", 64'(rate_valid), 64'd0);
        idle(4, 1);
      end
    end
    chk("s1_valid", 64'(rate_valid), 64'd1);
    chk("s1_rate", 64'(rate_out), 64'd10);
    chk("s1_sum", 64'(sum_out), 64'd80);
    chk("s1_filled", 64'(filled), 64'd1);
    idle(2, 1);

    // 2: sliding window in RUN
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 1, 32'd18, 1);
      chk("s2_sum", 64'(sum_out), 64'(exp_sum[i]));
      chk("s2_rate", 64'(rate_out), 64'(exp_rate[i]));
      chk("s2_ovr", 64'(overrun), 64'd0);
      idle(1, 1);
    end

    // 3: overrun while the consumer stalls
    cycle(0, 0, 1, 32'd26, 0);
    idle(1, 0);
    cycle(0, 0, 1, 32'd34, 0);
    chk("s3_ovr", 64'(overrun), 64'd1);
    chk("s3_valid", 64'(rate_valid), 64'd1);
    chk("s3_rate", 64'(rate_out), 64'd19);
    idle(2, 0);
    chk("s3_stable", 64'(rate_out), 64'd19);
    cycle(0, 0, 0, 32'd0, 1);
    chk("s3_consumed", 64'(rate_valid), 64'd0);
    chk("s3_sticky", 64'(overrun), 64'd1);

    // 4: clear wins over a coincident strobe
    cycle(0, 1, 1, 32'd99, 1);
    chk("s4_sum", 64'(sum_out), 64'd0);
    chk("s4_filled", 64'(filled), 64'd0);
    chk("s4_ovr", 64'(overrun), 64'd0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 1, 32'd10, 1);
      if (i < 7) idle(2, 1);
    end
    chk("s4_rate", 64'(rate_out), 64'd10);
    chk("s4_sum80", 64'(sum_out), 64'd80);

    // 5: full-scale counts back to back, no wrap
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 32'hFFFF_FFFF, 1);
    chk("s5_sum", 64'(sum_out), 64'h7_FFFF_FFF8);
    chk("s5_rate", 64'(rate_out), 64'hFFFF_FFFF);
    cycle(0, 0, 1, 32'd0, 1);
    chk("s5_sum2", 64'(sum_out), 64'h6_FFFF_FFF9);
    chk("s5_rate2", 64'(rate_out), 64'hDFFF_FFFF);

    // 6: truncating average, then reset with a pending result
    cycle(1, 0, 0, 32'd0, 1);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 32'd0, 0);
    cycle(0, 0, 1, 32'd7, 0);
    chk("s6_sum", 64'(sum_out), 64'd7);
    chk("s6_rate", 64'(rate_out), 64'd0);
    chk("s6_valid", 64'(rate_valid), 64'd1);
    cycle(1, 0, 0, 32'd0, 0);
    chk("s6_rst_sum", 64'(sum_out), 64'd0);
    chk("s6_rst_valid", 64'(rate_valid), 64'd0);
    chk("s6_rst_filled", 64'(filled), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] v;
      v = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 1) == 1), v, ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
